noc_flit_injector: RTL
======================

// Module: noc_flit_injector
// PURPOSE
//   Endpoint-side transmitter into one router input port. Accepts flits from local logic over valid/ready,
//   buffers them, and drives send/data/dest/is_tail towards the router under credit-based flow control,
//   consuming one credit per flit and restoring one per credit_in pulse. Latches dest at packet head so all
//   flits of a packet carry the same dest. Sits between an endpoint and router.data_in/send_in/credit_out.
// PARAMETERS
//   FLIT_WIDTH         32  flit payload width
//   DEST_WIDTH         1   destination id width
//   FLIT_BUFFER_DEPTH  4   router input buffer depth = initial credit count (>=1)
//   TX_FIFO_DEPTH      4   local staging FIFO depth (power of 2, >=2)
// PORTS
//   clk           in   1            clock
//   rst_n         in   1            synchronous reset, active-low
//   in_data       in   FLIT_WIDTH   local flit payload
//   in_dest       in   DEST_WIDTH   destination; sampled only on head flit
//   in_is_tail    in   1            last flit of packet (single-flit packet: head and tail)
//   in_valid      in   1            local flit valid
//   in_ready      out  1            FIFO can accept (not full)
//   data_out      out  FLIT_WIDTH   flit to router (registered)
//   dest_out      out  DEST_WIDTH   destination to router (registered)
//   is_tail_out   out  1            tail marker to router (registered)
//   send_out      out  1            one-cycle pulse per flit transferred (registered)
//   credit_in     in   1            one-cycle pulse: router freed one buffer slot
//   credit_count  out  $clog2(FLIT_BUFFER_DEPTH+1)  credits currently held
//   credit_err    out  1            sticky: credit_in received while credit_count == FLIT_BUFFER_DEPTH
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): FIFO empty, in_ready=0 during reset then 1, send_out=0, data_out/dest_out=0,
//     is_tail_out=0, credit_count=FLIT_BUFFER_DEPTH, credit_err=0, head state = HEAD. Reset mid-packet
//     discards FIFO contents and partial packet; no flits issued in reset cycle.
//   Accept: in_valid && in_ready at posedge writes {data, dest_eff, is_tail} to FIFO.
//   Head tracking FSM: HEAD -> (accept && !in_is_tail) -> BODY; BODY -> (accept && in_is_tail) -> HEAD.
//     In HEAD, dest_eff=in_dest and it is latched; in BODY, dest_eff=latched dest (in_dest ignored).
//   Issue: at posedge, if FIFO non-empty && credit_count != 0: pop head entry into output regs, send_out=1
//     next cycle; else send_out=0 (data/dest/tail regs hold last value). Max one flit/cycle.
//   Latency: flit accepted at edge N into empty FIFO with credits -> send_out high in cycle after edge N+1.
//   Credits: count-1 on issue, +1 on credit_in; both same edge -> unchanged. credit_in takes effect
//     next edge (no same-cycle bypass from credit_in to issue). count==0 blocks issue; FIFO keeps filling.
//   Overflow: credit_in with count==FLIT_BUFFER_DEPTH and no issue -> count saturates, credit_err set until reset.
//   FIFO full and pop same edge: in_ready reflects pre-edge occupancy (no write-through of full).
//   FIFO empty with accept same edge: no bypass; flit issues on later edge.
//   Flits leave in acceptance order; packets never interleave (single stream).
// STRUCTURE
//   noc_pkg: flit_t struct {data, dest, is_tail} parameterised via localparams; credit width function.
//   Sub-module noc_sync_fifo (depth TX_FIFO_DEPTH, width of flit_t, full/empty, push/pop) holds staging;
//   top holds head FSM, credit counter, output registers.
// TESTING (FLIT_BUFFER_DEPTH=4, TX_FIFO_DEPTH=4, bench loops send_out back as credit_in after 2 cycles)
//   Reset: after 3 reset cycles -> credit_count=4, send_out=0, credit_err=0, in_ready=1.
//   Single flit data=32'h1 dest=1 tail=1 -> send_out one cycle later+1, data_out=1, dest_out=1, count 4->3->4.
//   3-flit packet dest=0 then in_dest toggled 1,0 on body flits -> all three dest_out=0, tail only on 3rd.
//   credit_in held 0, 8 flits pushed -> exactly 4 send_out pulses, count=0, in_ready=0 after FIFO holds 4;
//     then 4 credit_in pulses -> remaining 4 flits issue in order, count returns to 4 after credit loopback.
//   Simultaneous issue and credit_in each cycle in streaming -> count constant, one flit/cycle throughput.
//   Spurious credit_in at count=4 -> credit_err=1 sticky, count stays 4; rst_n low mid-packet -> FIFO
//     flushed, no send_out after reset, next flit treated as head.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC endpoint injector: flit layout,
// head-tracking state and the credit counter width.
package noc_pkg;

  localparam int NOC_FLIT_WIDTH = 32;
  localparam int NOC_DEST_WIDTH = 1;

  typedef struct packed {
    logic [NOC_FLIT_WIDTH-1:0] data;
    logic [NOC_DEST_WIDTH-1:0] dest;
    logic                      is_tail;
  } flit_t;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } head_state_e;

  // Counter must be able to hold the full credit pool, including the value 'depth'.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock staging FIFO with pointer-wrap full/empty detection and a
// combinational head read so the consumer can pop straight into its own registers.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_flit_injector.sv
// Endpoint transmitter into a router input port: stages local flits, pins the
// destination for a whole packet, and issues flits under credit flow control.
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH        = NOC_FLIT_WIDTH,
  parameter int DEST_WIDTH        = NOC_DEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int TX_FIFO_DEPTH     = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [FLIT_WIDTH-1:0]                        in_data,
  input  logic [DEST_WIDTH-1:0]                        in_dest,
  input  logic                                         in_is_tail,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  output logic [FLIT_WIDTH-1:0]                        data_out,
  output logic [DEST_WIDTH-1:0]                        dest_out,
  output logic                                         is_tail_out,
  output logic                                         send_out,
  input  logic                                         credit_in,
  output logic [credit_width(FLIT_BUFFER_DEPTH)-1:0]   credit_count,
  output logic                                         credit_err
);

  localparam int             CW         = credit_width(FLIT_BUFFER_DEPTH);
  localparam int             FW         = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [CW-1:0]  CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);

  head_state_e           state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_lat_q, dest_lat_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  err_q, err_d;
  logic                  send_q, send_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  tail_q, tail_d;

  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_rdata;
  logic [FLIT_WIDTH-1:0] head_data;
  logic [DEST_WIDTH-1:0] head_dest;
  logic                  head_tail;
  logic [DEST_WIDTH-1:0] dest_eff;
  logic                  accept;
  logic                  issue;

  // Ready is held low while reset is asserted so nothing is accepted in that cycle.
  assign in_ready = rst_n && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign issue    = !fifo_empty && (credit_q != '0);
  assign dest_eff = (state_q == HEAD) ? in_dest : dest_lat_q;
  assign {head_data, head_dest, head_tail} = fifo_rdata;

  noc_sync_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (FW)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata ({in_data, dest_eff, in_is_tail}),
    .pop   (issue),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    dest_lat_d = dest_lat_q;
    credit_d   = credit_q;
    err_d      = err_q;
    send_d     = issue;
    data_d     = data_q;
    dest_d     = dest_q;
    tail_d     = tail_q;

    if (accept) begin
      if (state_q == HEAD) begin
        dest_lat_d = in_dest;
        if (!in_is_tail) state_d = BODY;
      end else if (in_is_tail) begin
        state_d = HEAD;
      end
    end

    // A return that coincides with an issue cancels out; an extra return at full pool is an error.
    case ({issue, credit_in})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CREDIT_MAX) err_d = 1'b1;
        else                        credit_d = credit_q + 1'b1;
      end
      default: ;
    endcase

    if (issue) begin
      data_d = head_data;
      dest_d = head_dest;
      tail_d = head_tail;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HEAD;
      dest_lat_q <= '0;
      credit_q   <= CREDIT_MAX;
      err_q      <= 1'b0;
      send_q     <= 1'b0;
      data_q     <= '0;
      dest_q     <= '0;
      tail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_lat_q <= dest_lat_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
      send_q     <= send_d;
      data_q     <= data_d;
      dest_q     <= dest_d;
      tail_q     <= tail_d;
    end
  end

  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign send_out     = send_q;
  assign credit_count = credit_q;
  assign credit_err   = err_q;

endmodule
